card_dealer: RTL

CARD_DEALER -- requirements
Module: card_dealer

---
 rtl/card_dealer.sv | 109 ++++++++++
 1 files changed

// File: rtl/card_dealer.sv
// Card dealer: deals unique cards from a 52-card deck seeded by a free-running
// count, resolving collisions by linear probing, then holds for a 2-second delay.
module card_dealer #(
  parameter int WIDTH    = 12,
  parameter int TICKS_2S = 4000
) (
  input  logic             clk_50M,
  input  logic             i_Reset_n,
  input  logic             i_Tick2K,
  input  logic [WIDTH-1:0] i_Random,
  input  logic             i_Draw,
  input  logic             i_Shuffle,
  output logic             o_Busy,
  output logic             o_CardValid,
  output logic [5:0]       o_Card,
  output logic [3:0]       o_Rank,
  output logic [3:0]       o_Points,
  output logic [5:0]       o_Remaining,
  output logic             o_DeckEmpty
);

  // state | meaning
  // IDLE  | wait for draw or shuffle request
  // PROBE | walk from idx to the first undealt slot
  // MARK  | claim slot, load card outputs, clear tick counter
  // WAIT  | hold until TICKS_2S 2 kHz ticks have elapsed
  // DONE  | present the card for one cycle
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PROBE = 3'd1,
    MARK  = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int CNT_W = $clog2(TICKS_2S + 1);

  state_t           state;
  logic [51:0]      used_mask;
  logic [5:0]       idx;
  logic [CNT_W-1:0] tick_cnt;
  logic [WIDTH-1:0] rand_mod;
  logic [5:0]       idx_mod13;
  logic [3:0]       rank_next;

  assign rand_mod    = i_Random % WIDTH'(52);
  assign idx_mod13   = idx % 6'd13;
  assign rank_next   = idx_mod13[3:0] + 4'd1;
  assign o_Busy      = (state != IDLE);
  assign o_DeckEmpty = (o_Remaining == 6'd0);

  always_ff @(posedge clk_50M or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state       <= IDLE;
      used_mask   <= '0;
      idx         <= '0;
      tick_cnt    <= '0;
      o_CardValid <= 1'b0;
      o_Card      <= '0;
      o_Rank      <= '0;
      o_Points    <= '0;
      o_Remaining <= 6'd52;
    end else begin
      o_CardValid <= 1'b0;
      case (state)
        IDLE: begin
          // shuffle takes priority and swallows any same-cycle draw
          if (i_Shuffle) begin
            used_mask   <= '0;
            o_Remaining <= 6'd52;
          end else if (i_Draw && (o_Remaining != 6'd0)) begin
            idx   <= rand_mod[5:0];
            state <= PROBE;
          end
        end
        PROBE: begin
          if (!used_mask[idx]) begin
            state <= MARK;
          end else begin
            idx <= (idx == 6'd51) ? 6'd0 : idx + 6'd1;
          end
        end
        MARK: begin
          used_mask[idx] <= 1'b1;
          o_Remaining    <= o_Remaining - 6'd1;
          o_Card         <= idx;
          o_Rank         <= rank_next;
          o_Points       <= (rank_next > 4'd10) ? 4'd10 : rank_next;
          tick_cnt       <= '0;
          state          <= WAIT;
        end
        WAIT: begin
          if (i_Tick2K) begin
            if (tick_cnt == CNT_W'(TICKS_2S - 1)) begin
              state       <= DONE;
              o_CardValid <= 1'b1;
            end
            tick_cnt <= tick_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
